if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
Instruction-fetch stage. Owns the PC and issues word fetches to instruction memory over a req/ack handshake. It presents each fetched instruction and its address (if_pc, if_inst, if_valid) to the IF/ID pipeline register. It also handles downstream stall, branch redirect, and slow (multi-cycle) memory responses, using a one-entry skid buffer.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; first fetch address.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous reset, active-high (RstEnable = 1'b1).
stall_i  input  1  downstream not accepting; the presented instruction must be held.
branch_flag_i  input  1  one-cycle redirect request from decode.
branch_target_i  input  32  redirect address; bits [1:0] are ignored and forced to 00.
inst_req  output  1  fetch request to instruction memory.
inst_addr  output  32  fetch address; word-aligned.
inst_ack  input  1  memory response strobe; inst_rdata is valid in the same cycle.
inst_rdata  input  32  fetched instruction word.
if_pc  output  32  address of the presented instruction.
if_inst  output  32  presented instruction.
if_valid  output  1  if_pc/if_inst hold a live instruction.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC; inst_req=0; inst_addr=0; if_pc=0; if_inst=0; if_valid=0.
  - Skid buffer empty; state=IDLE.
  - Reset overrides everything, including an outstanding request; any later inst_ack from that old request is ignored while in IDLE.
- States:
  - IDLE: one cycle after reset with inst_req=0, then REQ.
  - REQ: inst_req=1, inst_addr=pc.
  - FULL: skid occupied; inst_req=0.
  - DISCARD: request outstanding but redirected.
- Handshake: once raised, inst_req and inst_addr stay stable until the cycle inst_ack=1. A request is never withdrawn early. Memory latency is arbitrary (>=1 cycle, ack may be same cycle as req).
- Consume: the output slot is consumed on any cycle with if_valid=1 and stall_i=0.
- Ack in REQ (no branch), with pc advancing to pc+4 in every case:
  - Slot empty or being consumed this cycle: if_pc<=pc, if_inst<=inst_rdata, if_valid<=1; stay in REQ, so the next request issues back-to-back next cycle.
  - Slot occupied and stall_i=1: word and pc go to skid; state=FULL.
- FULL: when the slot is consumed, skid moves to output (if_valid stays 1) and state returns to REQ. No request is issued while in FULL.
- Throughput: 1 instruction/cycle with single-cycle ack and no stall.
- Stall with nothing outstanding in REQ: keep issuing. At most one output plus one skid entry is ever buffered.
- Branch (branch_flag_i=1) has priority over stall and ack:
  - pc<=branch_target_i & ~3; if_valid<=0; skid cleared.
  - Request outstanding without ack this cycle: state=DISCARD. In DISCARD inst_req stays high at the old address until ack, the data is dropped, then REQ at the new pc.
  - Ack in the same cycle as the branch: data dropped; REQ next cycle at the target.
  - Branch in DISCARD: update pc only and stay in DISCARD.
- Arithmetic: pc+4 modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
- Output stability: if_pc/if_inst change only when a new word loads or on reset/flush. When if_valid=0 their values are don't-care except after reset (0).

Test Plan:
1. Reset, then single-cycle ack memory returning inst = addr^0xA5A5A5A5, stall_i=0 -> inst_addr sequence 0,4,8,C on consecutive cycles; if_pc trails by one cycle; if_valid=1 every cycle from the 3rd cycle after reset release.
2. Memory with 3-cycle latency -> inst_req high with inst_addr=0x0 stable for 3 cycles; if_valid pulses once per 3 cycles (more precisely, the slot updates once per fetch); pc steps by 4 only on ack.
3. stall_i=1 for 5 cycles during streaming -> if_pc/if_inst frozen; at most one further ack absorbed into skid; inst_req=0 in FULL. Release stall -> words 0x10,0x14 delivered in order, none lost or duplicated.
4. branch_flag_i with target 0x00000103 while a 2-cycle request to 0x8 is outstanding -> if_valid=0 next cycle; the 0x8 data is never presented; next request and next if_pc = 0x00000100.
5. Branch in the same cycle as an ack and stall_i=1 -> acked word dropped; if_valid=0; REQ at target next cycle.
6. RESET_PC=0xFFFFFFF8, single-cycle memory -> addresses FFFFFFF8, FFFFFFFC, 00000000. Assert rst mid-request -> all outputs 0 next cycle; a late ack is ignored.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a req/ack
// handshake and presents fetched words to the IF/ID register. One output
// slot plus a one-entry skid buffer absorbs a fetch that completes while
// the slot is stalled; redirects drop in-flight data.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;         // next address to fetch (or redirect target)
  logic [31:0] pend_addr;  // address of a request orphaned by a redirect
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;  // skid is occupied exactly when state == S_FULL

  logic        consume;
  logic [31:0] pc_next;
  logic [31:0] br_pc;

  assign consume = if_valid & ~stall_i;
  assign pc_next = pc + 32'd4;  // wraps modulo 2^32
  assign br_pc   = {branch_target_i[31:2], 2'b00};

  // Memory request: REQ fetches at pc; DISCARD must keep the orphaned
  // request stable at its original address until memory acknowledges it.
  always_comb begin
    inst_req  = 1'b0;
    inst_addr = 32'h0;
    case (state)
      S_REQ: begin
        inst_req  = 1'b1;
        inst_addr = pc;
      end
      S_DISCARD: begin
        inst_req  = 1'b1;
        inst_addr = pend_addr;
      end
      default: ;
    endcase
  end

  // Fetch control, output slot and skid buffer. Redirect outranks stall and
  // ack; an ack landing with the redirect is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      pend_addr <= 32'h0;
      skid_pc   <= 32'h0;
      skid_inst <= 32'h0;
      if_pc     <= 32'h0;
      if_inst   <= 32'h0;
      if_valid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Acks seen here belong to a request killed by reset: ignored.
          state <= S_REQ;
          if (branch_flag_i) pc <= br_pc;
        end

        S_REQ: begin
          if (branch_flag_i) begin
            pc       <= br_pc;
            if_valid <= 1'b0;
            if (!inst_ack) begin
              // Cannot withdraw the request; remember it and drain it.
              pend_addr <= pc;
              state     <= S_DISCARD;
            end
          end else if (inst_ack) begin
            pc <= pc_next;
            if (!if_valid || !stall_i) begin
              if_pc    <= pc;
              if_inst  <= inst_rdata;
              if_valid <= 1'b1;
            end else begin
              skid_pc   <= pc;
              skid_inst <= inst_rdata;
              state     <= S_FULL;
            end
          end else if (consume) begin
            if_valid <= 1'b0;
          end
        end

        S_FULL: begin
          if (branch_flag_i) begin
            pc       <= br_pc;
            if_valid <= 1'b0;
            state    <= S_REQ;
          end else if (consume) begin
            // Skid drains into the slot; if_valid stays high.
            if_pc   <= skid_pc;
            if_inst <= skid_inst;
            state   <= S_REQ;
          end
        end

        S_DISCARD: begin
          // Slot is already empty here; only track further redirects.
          if (branch_flag_i) pc <= br_pc;
          if (inst_ack) state <= S_REQ;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: randomized stall/redirect/latency stimulus, a
// random-latency memory model, and a scoreboard holding the expected
// program-order address stream (sequential from reset or redirect target).
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFFFFF0;
  localparam logic [31:0] XOR_K  = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack = 1'b0;
  logic [31:0] inst_rdata = 32'h0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int n_checks = 0;
  int n_fail   = 0;

  int max_lat  = 1;
  bit late_ack = 1'b0;

  logic [31:0] exp_q[$];

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_ack(inst_ack), .inst_rdata(inst_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference stream: after reset or redirect, the next instructions seen
  // by decode are consecutive words from that start address.
  always @(posedge clk) begin
    logic [31:0] nxt;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(RST_PC);
    end else if (branch_flag_i) begin
      exp_q.delete();
      exp_q.push_back(branch_target_i & ~32'd3);
    end
    while (exp_q.size() < 4) begin
      nxt = exp_q[$] + 32'd4;
      exp_q.push_back(nxt);
    end
  end

  // Memory: random latency 1..max_lat, data = addr ^ XOR_K; checks that a
  // raised request stays put until acked and is never withdrawn.
  bit          busy = 1'b0;
  logic [31:0] busy_addr;
  int          wait_n;
  always begin
    bit was_rst, was_ack;
    @(posedge clk);
    was_rst = rst;
    was_ack = inst_ack;
    #2;
    if (was_rst || was_ack) busy = 1'b0;
    inst_ack   = 1'b0;
    inst_rdata = $urandom;
    if (late_ack) begin
      inst_ack   = 1'b1;
      inst_rdata = 32'hDEADBEEF;
    end else if (inst_req) begin
      if (busy) begin
        chk(inst_addr === busy_addr, "req_addr_stable", inst_addr, busy_addr);
      end else begin
        busy      = 1'b1;
        busy_addr = inst_addr;
        wait_n    = $urandom_range(0, max_lat - 1);
        chk(inst_addr[1:0] === 2'b00, "req_aligned", inst_addr, inst_addr & ~32'd3);
      end
      if (wait_n == 0) begin
        inst_ack   = 1'b1;
        inst_rdata = inst_addr ^ XOR_K;
      end else begin
        wait_n--;
      end
    end else if (busy) begin
      chk(1'b0, "req_withdrawn", {31'h0, inst_req}, 32'h1);
      busy = 1'b0;
    end
  end

  // Monitor: consumed words against the scoreboard, plus flush/hold/skid
  // properties across each clock edge.
  bit          p_rst = 1'b1, p_br = 1'b0, p_hold = 1'b0;
  logic [31:0] p_pc, p_inst;
  int          sk_acks = 0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (!p_rst && p_br)
      chk(if_valid === 1'b0, "branch_flush", {31'h0, if_valid}, 32'h0);
    if (!p_rst && !p_br && p_hold) begin
      chk(if_valid === 1'b1, "stall_hold_valid", {31'h0, if_valid}, 32'h1);
      chk(if_pc === p_pc, "stall_hold_pc", if_pc, p_pc);
      chk(if_inst === p_inst, "stall_hold_inst", if_inst, p_inst);
    end
    if (if_valid === 1'b1 && stall_i && !branch_flag_i && !rst) begin
      if (inst_ack) begin
        sk_acks++;
        chk(sk_acks <= 1, "skid_overflow", sk_acks, 32'd1);
      end
    end else begin
      sk_acks = 0;
    end
    if (if_valid === 1'b1 && !stall_i) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "stream_empty", if_pc, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk(if_pc === e, "stream_pc", if_pc, e);
        chk(if_inst === (e ^ XOR_K), "stream_inst", if_inst, e ^ XOR_K);
      end
    end
    p_rst  = rst;
    p_br   = branch_flag_i;
    p_hold = (if_valid === 1'b1) && stall_i;
    p_pc   = if_pc;
    p_inst = if_inst;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(inst_req === 1'b0, {tag, "_req"}, {31'h0, inst_req}, 32'h0);
    chk(inst_addr === 32'h0, {tag, "_addr"}, inst_addr, 32'h0);
    chk(if_pc === 32'h0, {tag, "_if_pc"}, if_pc, 32'h0);
    chk(if_inst === 32'h0, {tag, "_if_inst"}, if_inst, 32'h0);
    chk(if_valid === 1'b0, {tag, "_if_valid"}, {31'h0, if_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] ea;
    int stall_pct;

    // Reset and single-cycle streaming: one fetch per cycle, wrapping PC.
    cyc(); cyc();
    @(negedge clk);
    chk_reset_outputs("reset");
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk(inst_req === 1'b0, "idle_no_req", {31'h0, inst_req}, 32'h0);
    cyc();
    @(negedge clk);
    chk(inst_req === 1'b1, "first_req", {31'h0, inst_req}, 32'h1);
    chk(inst_addr === RST_PC, "first_addr", inst_addr, RST_PC);
    for (int i = 1; i <= 12; i++) begin
      cyc();
      @(negedge clk);
      ea = RST_PC + 32'(4 * i);
      chk(inst_addr === ea, "stream_addr", inst_addr, ea);
      chk(if_valid === 1'b1, "throughput_valid", {31'h0, if_valid}, 32'h1);
    end

    // Multi-cycle memory then reset mid-request, with a stray ack arriving
    // during reset and the idle cycle after it.
    max_lat = 3;
    repeat (10) cyc();
    cyc();
    rst = 1'b1;
    late_ack = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreq_reset");
    cyc();
    late_ack = 1'b0;
    @(negedge clk);
    chk(inst_req === 1'b1, "post_reset_req", {31'h0, inst_req}, 32'h1);
    chk(inst_addr === RST_PC, "post_reset_addr", inst_addr, RST_PC);

    // Directed redirect to an unaligned target during a 2-cycle fetch.
    max_lat = 2;
    repeat (6) cyc();
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h00000103;
    cyc();
    branch_flag_i = 1'b0;
    repeat (8) cyc();

    // Randomized: latency, stall density, redirects, occasional reset.
    stall_pct = 30;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if (i % 500 == 0) begin
        max_lat   = $urandom_range(1, 4);
        stall_pct = $urandom_range(0, 70);
      end
      rst             = ($urandom_range(0, 299) == 0);
      stall_i         = ($urandom_range(0, 99) < stall_pct);
      branch_flag_i   = !rst && ($urandom_range(0, 99) < 6);
      branch_target_i = ($urandom_range(0, 3) == 0) ?
                        (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
    end
    cyc();
    rst = 1'b0;
    stall_i = 1'b0;
    branch_flag_i = 1'b0;
    repeat (10) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
